match_unit: RTL and testbench
=============================

# match_unit

Multi-cycle byte-pattern search unit for the SampleCPU EX stage. It is the sequential counterpart of the ALU `op_match` path. EX issues a pattern byte and a 32-bit word. The unit scans 8-bit windows of the word from bit 0 upward, one window per cycle, and returns the lowest bit position where the window equals the pattern. While the search runs it holds the pipeline through a stall request, and it reports completion with a one-cycle `ready_o` pulse.

## Interface
- No parameters. Constants come from `defines.vh`.
- `clk`  in  1  — the single clock; all state updates on its rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start_i`  in  1  — request a search; sampled only in IDLE.
- `cancel_i`  in  1  — pipeline flush; aborts a search in progress.
- `pattern_i`  in  8  — byte to search for; latched on an accepted start.
- `data_i`  in  32  — word to search; latched on an accepted start.
- `result_o`  out  32  — match position 0..24, or `MATCH_NONE` (32'hFFFF_FFFF).
- `ready_o`  out  1  — one-cycle pulse; `result_o` is valid in this cycle.
- `stallreq_o`  out  1  — stall request to the pipeline controller.

## Operation
- State machine: IDLE → SCAN → DONE → IDLE.
- IDLE
  - `start_i & ~cancel_i`: latch `pattern_i`/`data_i`, set idx = 0, go to SCAN.
  - Otherwise stay in IDLE.
- SCAN, each cycle:
  - Compare `data_q[idx+7:idx]` with `pattern_q`.
  - Equal: `result_o <= idx` (zero-extended), go to DONE.
  - Not equal and idx == `MATCH_LAST_POS` (24): `result_o <= MATCH_NONE`, go to DONE.
  - Otherwise idx <= idx + 1.
- DONE: `ready_o = 1`, go to IDLE unconditionally.
  - A `start_i` seen in DONE is not accepted. EX still sees its stall released in this cycle and must re-issue.
- idx is 5 bits and never exceeds 24, so it never wraps. Windows never read past bit 31.
- When several windows match, the lowest position wins. Example: pattern 8'h00, data 0 gives result 0.
- `stallreq_o` is combinational:
  - High when (state == IDLE & `start_i` & ~`cancel_i`), or when state == SCAN.
  - Low in DONE, so the stalled instruction advances in the same cycle it captures `result_o`.
- `cancel_i`
  - In SCAN: next state is IDLE, no `ready_o`, `result_o` unchanged.
  - In IDLE: beats `start_i` in the same cycle; no start is accepted.
  - In DONE: ignored; the pulse still occurs.
- `start_i` during SCAN or DONE is ignored.
- `result_o` holds its last value until the next completed search.

## Timing
- Reset values: state = IDLE, idx = 0, `result_o` = 0, `ready_o` = 0, `stallreq_o` = 0.
- `rst` mid-scan: IDLE on the next edge with all reset values. `rst` beats `start_i` and `cancel_i`.
- Latency, with start accepted in cycle T:
  - Match at position k: `ready_o` in cycle T+k+2.
  - No match: `ready_o` in cycle T+26.
- `stallreq_o` is high from T through T+k+1.
- Throughput: one search per (latency + 1) cycles at best, because of the IDLE re-entry.

## Structure
- Add to `defines.vh`:
  - `MATCH_NONE` (32'hFFFF_FFFF).
  - `MATCH_LAST_POS` (5'd24).
  - State encodings `MATCH_IDLE`/`MATCH_SCAN`/`MATCH_DONE` (2 bits).
  - `MATCH_RES_WD` (32).
- Single module. The window compare is one equality on a variable part-select (`data_q >> idx`, low 8 bits), so no sub-module is warranted.
- EX ORs `stallreq_o` into the existing EX stall request and muxes `result_o` onto the EX result when the decoded op is a match.

## Test plan
- Match at position 0: pattern 8'hAB, data 32'h0000_00AB, start in T → `ready_o` at T+2, result 0; `stallreq_o` high in T and T+1, low in T+2.
- Match at position 8: pattern 8'h01, data 32'h0000_0100 → result 8 (positions 1..7 read 8'h80..8'h02), `ready_o` at T+10.
- Match at position 24: pattern 8'h5A, data 32'h5A00_0000 → result 24, `ready_o` at T+26.
- No match: pattern 8'hFF, data 0 → result 32'hFFFF_FFFF, `ready_o` at T+26.
- Cancel: pattern 8'h5A, data 32'h5A00_0000, `cancel_i` at T+5 → no `ready_o`, IDLE at T+6 with `stallreq_o` low, `result_o` keeps its prior value; a new start at T+6 is accepted.
- Reset and same-cycle priority:
  - `rst` at T+3 of a no-match search → all outputs 0 from T+4; no `ready_o` ever appears.
  - `start_i` with `cancel_i` in IDLE → no start accepted.

Source files
------------

// File: rtl/match_unit_pkg.sv
// Shared constants, state encoding and window helper
// for the match_unit byte-pattern search.
package match_unit_pkg;

    localparam int unsigned MATCH_RES_WD = 32;
    localparam logic [MATCH_RES_WD-1:0] MATCH_NONE = 32'hFFFF_FFFF;
    localparam logic [4:0] MATCH_LAST_POS = 5'd24;

    typedef enum logic [1:0] {
        MATCH_IDLE = 2'd0,
        MATCH_SCAN = 2'd1,
        MATCH_DONE = 2'd2
    } match_state_e;

    function automatic logic [7:0] window_at(
        input logic [31:0] data,
        input logic [4:0]  pos
    );
        return 8'(data >> pos);
    endfunction

endpackage

// File: rtl/match_unit.sv
// Multi-cycle byte-pattern search for the EX stage: one 8-bit
// window per cycle, lowest matching bit position wins.
module match_unit
    import match_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    cancel_i,
    input  logic [7:0]              pattern_i,
    input  logic [31:0]             data_i,
    output logic [MATCH_RES_WD-1:0] result_o,
    output logic                    ready_o,
    output logic                    stallreq_o
);

    match_state_e state;
    logic [4:0]   idx;
    logic [7:0]   pattern_q;
    logic [31:0]  data_q;
    logic         hit;
    logic         accept;

    assign hit    = window_at(data_q, idx) == pattern_q;
    assign accept = (state == MATCH_IDLE) & start_i & ~cancel_i;

    // Low in DONE so the stalled op advances while capturing the result.
    assign stallreq_o = accept | (state == MATCH_SCAN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MATCH_IDLE;
            idx       <= '0;
            pattern_q <= '0;
            data_q    <= '0;
            result_o  <= '0;
            ready_o   <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            unique case (state)
                MATCH_IDLE: begin
                    if (accept) begin
                        pattern_q <= pattern_i;
                        data_q    <= data_i;
                        idx       <= '0;
                        state     <= MATCH_SCAN;
                    end
                end
                MATCH_SCAN: begin
                    if (cancel_i) begin
                        state <= MATCH_IDLE;
                    end else if (hit) begin
                        result_o <= {27'd0, idx};
                        ready_o  <= 1'b1;
                        state    <= MATCH_DONE;
                    end else if (idx == MATCH_LAST_POS) begin
                        result_o <= MATCH_NONE;
                        ready_o  <= 1'b1;
                        state    <= MATCH_DONE;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                MATCH_DONE: begin
                    state <= MATCH_IDLE;
                end
                default: begin
                    state <= MATCH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_unit.sv
// Self-checking bench for match_unit: vector table, random
// searches against a bit-level reference, and corner sequences.
module tb_match_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        cancel_i;
    logic [7:0]  pattern_i;
    logic [31:0] data_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int checks;
    int failures;

    match_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .cancel_i   (cancel_i),
        .pattern_i  (pattern_i),
        .data_i     (data_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pat;
        logic [31:0] dat;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: scan positions 0..24 bit by bit, first full match wins.
    function automatic logic [31:0] ref_search(input logic [7:0] pat,
                                               input logic [31:0] dat);
        for (int k = 0; k <= 24; k++) begin
            bit ok = 1'b1;
            for (int b = 0; b < 8; b++)
                if (dat[k+b] != pat[b]) ok = 1'b0;
            if (ok) return 32'(k);
        end
        return 32'hFFFF_FFFF;
    endfunction

    function automatic int ref_lat(input logic [31:0] res);
        return (res == 32'hFFFF_FFFF) ? 26 : int'(res) + 2;
    endfunction

    task automatic run_search(input string tag, input logic [7:0] pat,
                              input logic [31:0] dat,
                              input logic [31:0] exp_res,
                              input int exp_lat);
        int lat = 0;
        int stall_bad = 0;
        @(negedge clk);
        pattern_i = pat;
        data_i    = dat;
        start_i   = 1'b1;
        #1;
        if (stallreq_o !== 1'b1) stall_bad++;
        @(posedge clk);
        #1;
        start_i   = 1'b0;
        pattern_i = ~pat;
        data_i    = ~dat;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            if (ready_o === 1'b1) lat = n;
            if (stallreq_o !== 1'(n < exp_lat)) stall_bad++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result_o, exp_res);
        check({tag, " stall"}, 32'(stall_bad), 32'd0);
        @(negedge clk);
        check({tag, " pulse end"}, {30'd0, ready_o, stallreq_o}, 32'd0);
    endtask

    task automatic watch_idle(input string tag, input logic [31:0] exp_res,
                              input int cycles);
        int bad = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (ready_o !== 1'b0 || stallreq_o !== 1'b0 ||
                result_o !== exp_res) bad++;
        end
        check({tag, " quiet"}, 32'(bad), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [7:0]  pat;
        logic [31:0] dat;
        logic [31:0] res;
        int          pos;
        int          ok;

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        start_i   = 1'b0;
        cancel_i  = 1'b0;
        pattern_i = '0;
        data_i    = '0;

        vecs[0] = '{8'hAB, 32'h0000_00AB, 32'd0, 2};
        vecs[1] = '{8'h01, 32'h0000_0100, 32'd8, 10};
        vecs[2] = '{8'h5A, 32'h5A00_0000, 32'd24, 26};
        vecs[3] = '{8'hFF, 32'h0000_0000, 32'hFFFF_FFFF, 26};
        vecs[4] = '{8'h00, 32'h0000_0000, 32'd0, 2};
        vecs[5] = '{8'h11, 32'h1111_0000, 32'd16, 18};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset result", result_o, 32'd0);
        check("reset ready", {31'd0, ready_o}, 32'd0);
        check("reset stall", {31'd0, stallreq_o}, 32'd0);

        for (int i = 0; i < 6; i++)
            run_search($sformatf("vec%0d", i), vecs[i].pat, vecs[i].dat,
                       vecs[i].exp_res, vecs[i].exp_lat);

        for (int i = 0; i < 40; i++) begin
            pat = 8'($urandom);
            dat = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                pos = $urandom_range(0, 24);
                dat = (dat & ~(32'hFF << pos)) | (32'(pat) << pos);
            end
            res = ref_search(pat, dat);
            run_search($sformatf("rnd%0d", i), pat, dat, res, ref_lat(res));
        end

        // Cancel at T+5 of a position-24 search; prior result is 8.
        run_search("pre cancel", 8'h01, 32'h0000_0100, 32'd8, 10);
        @(negedge clk);
        pattern_i = 8'h5A;
        data_i    = 32'h5A00_0000;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        ok = 0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (ready_o !== 1'b0 || stallreq_o !== 1'b1) ok++;
        end
        @(negedge clk);
        cancel_i = 1'b1;
        @(posedge clk);
        #1;
        cancel_i = 1'b0;
        check("cancel scan", 32'(ok), 32'd0);
        check("cancel stall", {31'd0, stallreq_o}, 32'd0);
        check("cancel ready", {31'd0, ready_o}, 32'd0);
        check("cancel hold", result_o, 32'd8);
        run_search("post cancel", 8'hAB, 32'h0000_00AB, 32'd0, 2);

        // Reset at T+3 of a no-match search.
        run_search("pre reset", 8'h5A, 32'h5A00_0000, 32'd24, 26);
        @(negedge clk);
        pattern_i = 8'hFF;
        data_i    = 32'h0;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        start_i = 1'b1;
        cancel_i = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_i = 1'b0;
        cancel_i = 1'b0;
        check("rst result", result_o, 32'd0);
        watch_idle("rst", 32'd0, 30);

        // start with cancel in IDLE is refused.
        run_search("pre sc", 8'h01, 32'h0000_0100, 32'd8, 10);
        pattern_i = 8'hAB;
        data_i    = 32'h0000_00AB;
        start_i   = 1'b1;
        cancel_i  = 1'b1;
        #1;
        check("sc stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        cancel_i = 1'b0;
        watch_idle("sc", 32'd8, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
